// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: synchronous AXI-Stream FIFO with multi-word beats, per-word keep, last and
// optional store-and-forward (packet) mode. Absorbs ready/valid back-pressure between an AXIS
// master and slave and exports its occupancy.
//
// Ports
//   clk, rstn          clock (posedge) and synchronous active-low reset
//   s_valid/s_ready    slave-side handshake; s_ready is registered (count < DEPTH)
//   s_data/s_keep      slave-side beat payload and per-word valid lanes
//   s_last             slave-side end of packet
//   m_valid/m_ready    master-side handshake
//   m_data/m_keep      master-side beat payload (all zero while m_valid is low)
//   m_last             master-side end of packet (zero while m_valid is low)
//   count              beats currently stored, 0..DEPTH
module axis_stream_fifo #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PACKET_MODE = 0,
    localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W,
    localparam int unsigned ADDR_W         = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
    input  logic [WORDS_PER_BEAT-1:0]              s_keep,
    input  logic                                   s_last,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data,
    output logic [WORDS_PER_BEAT-1:0]              m_keep,
    output logic                                   m_last,
    output logic [ADDR_W:0]                        count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // Storage, deliberately not reset.
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] mem_data [DEPTH];
    logic [WORDS_PER_BEAT-1:0]             mem_keep [DEPTH];
    logic                                  mem_last [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   pkt_cnt_q, pkt_cnt_d;
    logic              stream_q, stream_d;
    logic              s_ready_q, s_ready_d;

    logic push;
    logic pop;
    logic rd_last;
    logic valid_int;

    assign rd_last = mem_last[rd_ptr_q];

    // Output valid. In packet mode a beat is only offered once a complete frame is stored, or
    // when the FIFO is full with no complete frame (an over-long frame), in which case the
    // frame streams out until its last beat leaves.
    always_comb begin
        valid_int = 1'b0;
        if (PACKET_MODE == 0) begin
            valid_int = (count_q != '0);
        end else begin
            valid_int = (count_q != '0) &&
                        ((pkt_cnt_q != '0) || (count_q == FULL_CNT) || stream_q);
        end
    end

    assign push = s_valid && s_ready_q;
    assign pop  = valid_int && m_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        stream_d  = stream_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if ((push && s_last) && !(pop && rd_last)) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if ((pop && rd_last) && !(push && s_last)) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end

        // Streaming ends when the over-long frame's last beat leaves.
        if (pop && rd_last) begin
            stream_d = 1'b0;
        end else if ((PACKET_MODE != 0) && (count_q == FULL_CNT) && (pkt_cnt_q == '0)) begin
            stream_d = 1'b1;
        end

        // Based on next occupancy, so a pop at full re-opens s_ready one cycle later.
        s_ready_d = (count_d < FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            stream_q  <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            stream_q  <= stream_d;
            s_ready_q <= s_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_data[wr_ptr_q] <= s_data;
            mem_keep[wr_ptr_q] <= s_keep;
            mem_last[wr_ptr_q] <= s_last;
        end
    end

    always_comb begin
        m_data = '0;
        m_keep = '0;
        m_last = 1'b0;
        if (valid_int) begin
            m_data = mem_data[rd_ptr_q];
            m_keep = mem_keep[rd_ptr_q];
            m_last = rd_last;
        end
    end

    assign m_valid = valid_int;
    assign s_ready = s_ready_q;
    assign count   = count_q;

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo: directed bench for axis_stream_fifo. One cut-through and one packet-mode
// instance share the stimulus; sel routes the handshake to the instance under test.
module tb_axis_stream_fifo;

    localparam int unsigned DEPTH = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            sel;
    logic            s_valid;
    logic [1:0][7:0] s_data;
    logic [1:0]      s_keep;
    logic            s_last;
    logic            m_ready;

    logic            s_ready_c, m_valid_c, m_last_c;
    logic [1:0][7:0] m_data_c;
    logic [1:0]      m_keep_c;
    logic [4:0]      count_c;
    logic            s_ready_p, m_valid_p, m_last_p;
    logic [1:0][7:0] m_data_p;
    logic [1:0]      m_keep_p;
    logic [4:0]      count_p;

    logic            s_ready, m_valid, m_last;
    logic [1:0][7:0] m_data;
    logic [1:0]      m_keep;
    logic [4:0]      count;

    int n_vec = 0;
    int n_err = 0;
    logic [18:0] sb[$];

    always #5 clk = ~clk;

    axis_stream_fifo #(
        .WORD_W(8), .BUS_W(16), .DEPTH(DEPTH), .PACKET_MODE(0)
    ) dut_c (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid & ~sel), .s_ready(s_ready_c), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last),
        .m_valid(m_valid_c), .m_ready(m_ready & ~sel), .m_data(m_data_c), .m_keep(m_keep_c),
        .m_last(m_last_c), .count(count_c)
    );

    axis_stream_fifo #(
        .WORD_W(8), .BUS_W(16), .DEPTH(DEPTH), .PACKET_MODE(1)
    ) dut_p (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid & sel), .s_ready(s_ready_p), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last),
        .m_valid(m_valid_p), .m_ready(m_ready & sel), .m_data(m_data_p), .m_keep(m_keep_p),
        .m_last(m_last_p), .count(count_p)
    );

    assign s_ready = sel ? s_ready_p : s_ready_c;
    assign m_valid = sel ? m_valid_p : m_valid_c;
    assign m_data  = sel ? m_data_p  : m_data_c;
    assign m_keep  = sel ? m_keep_p  : m_keep_c;
    assign m_last  = sel ? m_last_p  : m_last_c;
    assign count   = sel ? count_p   : count_c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: score handshakes visible now, advance, then check stall stability.
    task automatic tick();
        logic [18:0] got;
        logic [18:0] exp;
        logic        stalled;
        logic [18:0] held;
        if (m_valid === 1'b1 && m_ready) begin
            got = {m_last, m_keep, m_data};
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            check_eq("beat", 32'(got), 32'(exp));
        end
        if (s_valid && s_ready === 1'b1) sb.push_back({s_last, s_keep, s_data});
        if (m_valid === 1'b0) check_eq("idle_zero", 32'({m_last, m_keep, m_data}), 32'd0);
        stalled = (m_valid === 1'b1) && !m_ready;
        held    = {m_last, m_keep, m_data};
        @(posedge clk);
        #1;
        if (stalled && rstn) begin
            check_eq("hold_valid", 32'(m_valid), 32'd1);
            check_eq("hold_data", 32'({m_last, m_keep, m_data}), 32'(held));
        end
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_last  = 1'b0;
        s_keep  = '0;
        s_data  = '0;
        @(posedge clk);
        #1;
        sb.delete();
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (sb.size() == 0 && m_valid === 1'b0) break;
            tick();
        end
        check_eq("drain_sb", 32'(sb.size()), 32'd0);
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_valid", 32'(m_valid), 32'd0);
    endtask

    task automatic rand_run(input logic sel_v, input int s_rate, input int m_rate,
                            input int nbeats);
        int  pushed;
        logic acc;
        sel = sel_v;
        do_reset();
        pushed = 0;
        for (int cyc = 0; cyc < 40000 && pushed < nbeats; cyc++) begin
            if (!s_valid && $urandom_range(99) < 32'(s_rate)) begin
                s_valid = 1'b1;
                s_data  = 16'($urandom);
                s_keep  = 2'($urandom);
                s_last  = (pushed == nbeats - 1) || ($urandom_range(5) == 0);
            end
            m_ready = ($urandom_range(99) < 32'(m_rate));
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                pushed++;
                s_valid = 1'b0;
            end
        end
        check_eq("rand_pushed", 32'(pushed), 32'(nbeats));
        drain();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   nxt;
        int   popped;
        int   rise;
        logic acc;

        // Reset values and s_ready release timing.
        sel     = 1'b0;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        rstn = 1'b1;
        check_eq("rst_ready_low", 32'(s_ready), 32'd0);
        tick();
        check_eq("rst_ready_rise", 32'(s_ready), 32'd1);

        // 1: three back-to-back beats, m_ready held.
        s_valid = 1'b1; s_keep = 2'b01;
        s_data = 16'h0011; s_last = 1'b0;
        tick();
        check_eq("t1_valid", 32'(m_valid), 32'd1);
        check_eq("t1_count_a", 32'(count), 32'd1);
        check_eq("t1_data_a", 32'(m_data), 32'h0011);
        s_data = 16'h0022;
        tick();
        check_eq("t1_count_b", 32'(count), 32'd1);
        check_eq("t1_data_b", 32'(m_data), 32'h0022);
        s_data = 16'h0033; s_last = 1'b1;
        tick();
        check_eq("t1_data_c", 32'(m_data), 32'h0033);
        check_eq("t1_last_c", 32'(m_last), 32'd1);
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        check_eq("t1_count_end", 32'(count), 32'd0);
        check_eq("t1_valid_end", 32'(m_valid), 32'd0);

        // 2: fill to full, one pop re-opens s_ready a cycle later.
        do_reset();
        nxt = 0;
        s_valid = 1'b1; s_keep = 2'b11; s_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s_data = 16'(nxt);
            acc = s_valid && s_ready;
            tick();
            if (acc) nxt++;
        end
        check_eq("t2_accepted", 32'(nxt), 32'd16);
        check_eq("t2_count_full", 32'(count), 32'd16);
        check_eq("t2_ready_full", 32'(s_ready), 32'd0);
        s_data = 16'(nxt);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("t2_count_pop", 32'(count), 32'd15);
        check_eq("t2_ready_pop", 32'(s_ready), 32'd1);
        tick();
        check_eq("t2_count_17", 32'(count), 32'd16);
        check_eq("t2_ready_17", 32'(s_ready), 32'd0);
        drain();

        // 3: full FIFO with s_valid and m_ready held; 40 beats across wrap-around.
        do_reset();
        nxt = 0;
        s_valid = 1'b1; s_keep = 2'b10; s_last = 1'b0;
        for (int c = 0; c < 16; c++) begin
            s_data = 16'(nxt);
            acc = s_valid && s_ready;
            tick();
            if (acc) nxt++;
        end
        check_eq("t3_full", 32'(count), 32'd16);
        m_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 80 && popped < 40; c++) begin
            s_data = 16'(nxt);
            acc = s_valid && s_ready;
            if (m_valid) popped++;
            tick();
            if (acc) nxt++;
            check_eq("t3_stream_valid", 32'(m_valid), 32'd1);
            check_eq("t3_stream_count", 32'(count), 32'(DEPTH - 1));
        end
        check_eq("t3_popped", 32'(popped), 32'd40);
        drain();

        // 4: packet mode, 5-beat frame released only after its last beat.
        sel = 1'b1;
        do_reset();
        m_ready = 1'b1;
        s_keep = 2'b11;
        for (int b = 0; b < 5; b++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h4000 + b);
            s_last  = (b == 4);
            tick();
            if (b < 4) check_eq("t4_hold", 32'(m_valid), 32'd0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        check_eq("t4_release", 32'(m_valid), 32'd1);
        check_eq("t4_count", 32'(count), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_last", 32'(m_last), 32'(k == 4));
            tick();
        end
        check_eq("t4_count_end", 32'(count), 32'd0);
        check_eq("t4_valid_end", 32'(m_valid), 32'd0);

        // 5: packet mode, 24-beat frame exceeds DEPTH and streams once full.
        do_reset();
        m_ready = 1'b1;
        nxt = 0;
        popped = 0;
        rise = -1;
        for (int c = 0; c < 200; c++) begin
            if (nxt == 24 && sb.size() == 0 && m_valid === 1'b0) break;
            if (m_valid && rise < 0) rise = int'(count);
            if (nxt < 24) begin
                s_valid = 1'b1;
                s_data  = 16'(16'h8000 + nxt);
                s_last  = (nxt == 23);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            acc = s_valid && s_ready;
            if (m_valid) popped++;
            tick();
            if (acc) nxt++;
        end
        check_eq("t5_rise_count", 32'(rise), 32'd16);
        check_eq("t5_pushed", 32'(nxt), 32'd24);
        check_eq("t5_popped", 32'(popped), 32'd24);
        check_eq("t5_count_end", 32'(count), 32'd0);
        check_eq("t5_pkt_cnt", 32'(dut_p.pkt_cnt_q), 32'd0);
        // Next short frame must wait for its last beat again.
        s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0;
        tick();
        check_eq("t5_next_hold", 32'(m_valid), 32'd0);
        s_data = 16'h0002; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check_eq("t5_next_release", 32'(m_valid), 32'd1);
        drain();

        // 6: reset mid-packet discards contents.
        sel = 1'b0;
        do_reset();
        s_keep = 2'b01; s_last = 1'b0;
        for (int b = 0; b < 7; b++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h0700 + b);
            tick();
        end
        s_valid = 1'b0;
        check_eq("t6_count7", 32'(count), 32'd7);
        rstn = 1'b0;
        tick();
        check_eq("t6_count0", 32'(count), 32'd0);
        check_eq("t6_valid0", 32'(m_valid), 32'd0);
        check_eq("t6_data0", 32'(m_data), 32'd0);
        check_eq("t6_ready0", 32'(s_ready), 32'd0);
        sb.delete();
        rstn = 1'b1;
        tick();
        check_eq("t6_ready1", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 16'h00a1; s_last = 1'b0;
        tick();
        check_eq("t6_first", 32'(m_data), 32'h00a1);
        s_data = 16'h00b2; s_last = 1'b1;
        tick();
        check_eq("t6_second", 32'({m_last, m_data}), 32'h100b2);
        s_last = 1'b0;
        drain();

        // 7: random handshakes, scoreboard-checked.
        rand_run(1'b0, 20, 90, 1000);
        rand_run(1'b0, 90, 20, 1000);
        rand_run(1'b0, 50, 50, 1000);
        rand_run(1'b1, 50, 50, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
